// File: rtl/nr_pkg.sv
// Shared encodings for the horizontal noise-reduction stream core.
package nr_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_TEST   = 2'd1,
    MODE_FILT   = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // [1 2 1] sum plus rounding needs two guard bits above the pixel width.
  function automatic int tap_w(input int pw);
    return pw + 2;
  endfunction

endpackage

// File: rtl/nr_tap3.sv
// Rounded [1 2 1]/4 tap on three same-colour pixels.
module nr_tap3
  import nr_pkg::*;
#(
  parameter int PW = 10
) (
  input  logic [PW-1:0] l,
  input  logic [PW-1:0] c,
  input  logic [PW-1:0] r,
  output logic [PW-1:0] y
);

  localparam int SW = tap_w(PW);

  // Max sum is 4*(2^PW-1)+2, so the shifted result always fits in PW bits.
  function automatic logic [PW-1:0] round_121(input logic [PW-1:0] a,
                                              input logic [PW-1:0] b,
                                              input logic [PW-1:0] d);
    logic [SW-1:0] s;
    s = SW'(a) + (SW'(b) << 1) + SW'(d) + SW'(2);
    return s[SW-1:2];
  endfunction

  assign y = round_121(l, c, r);

endmodule

// File: rtl/nr_hfilter_stream.sv
// RAW Bayer stream core: bypass, constant test pattern or horizontal
// same-colour [1 2 1]/4 filter, with one beat held back to see right neighbours.
module nr_hfilter_stream
  import nr_pkg::*;
#(
  parameter int                  PW         = 10,
  parameter int                  PPC        = 4,
  parameter logic [PPC*PW-1:0]   TP_PATTERN = 40'h4018060300
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [1:0]          mode,
  input  logic [PPC*PW-1:0]   in_data,
  input  logic                in_valid,
  input  logic                in_user,
  input  logic                in_last,
  output logic                in_ready,
  output logic [PPC*PW-1:0]   out_data,
  output logic                out_valid,
  output logic                out_user,
  output logic                out_last,
  input  logic                out_ready
);

  localparam int BW = PPC * PW;

  state_e            state_q, state_nxt;
  logic [1:0]        mode_q;
  logic [1:0]        beat_mode;
  logic              slot_free;
  logic              load_cur;
  logic              emit;
  logic              emit_last;
  logic              is_flush;

  logic [BW-1:0]     cur_data_p0;
  logic              cur_user_p0;
  logic [1:0]        cur_mode_p0;
  logic              cur_first_p0;
  logic [2*PW-1:0]   prev_tail_p0;

  logic [BW-1:0]     filt_data;
  logic [BW-1:0]     emit_data;

  assign slot_free = !out_valid || out_ready;
  assign is_flush  = (state_q == FLUSH);
  // An SOF beat takes the mode presented with it; other beats inherit the frame mode.
  assign beat_mode = in_user ? mode : mode_q;

  always_comb begin
    state_nxt = state_q;
    in_ready  = 1'b0;
    load_cur  = 1'b0;
    emit      = 1'b0;
    emit_last = 1'b0;
    case (state_q)
      EMPTY: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_cur  = 1'b1;
          state_nxt = in_last ? FLUSH : HOLD;
        end
      end
      HOLD: begin
        in_ready = slot_free;
        if (in_valid && slot_free) begin
          load_cur  = 1'b1;
          emit      = 1'b1;
          state_nxt = in_last ? FLUSH : HOLD;
        end
      end
      FLUSH: begin
        if (slot_free) begin
          emit      = 1'b1;
          emit_last = 1'b1;
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= EMPTY;
    else       state_q <= state_nxt;
  end

  // Filter taps: left edge from prev_tail or replicated, right edge from the
  // incoming beat or replicated when the held beat closes the line.
  for (genvar i = 0; i < PPC; i++) begin : g_tap
    logic [PW-1:0] l_px, c_px, r_px;
    assign c_px = cur_data_p0[i*PW +: PW];
    if (i >= 2) begin : g_l_in
      assign l_px = cur_data_p0[(i-2)*PW +: PW];
    end else begin : g_l_edge
      assign l_px = cur_first_p0 ? c_px : prev_tail_p0[i*PW +: PW];
    end
    if (i <= PPC - 3) begin : g_r_in
      assign r_px = cur_data_p0[(i+2)*PW +: PW];
    end else begin : g_r_edge
      assign r_px = is_flush ? c_px : in_data[(i-PPC+2)*PW +: PW];
    end
    nr_tap3 #(.PW(PW)) u_tap (
      .l (l_px),
      .c (c_px),
      .r (r_px),
      .y (filt_data[i*PW +: PW])
    );
  end

  always_comb begin
    case (cur_mode_p0)
      MODE_TEST: emit_data = TP_PATTERN;
      MODE_FILT: emit_data = filt_data;
      default:   emit_data = cur_data_p0;
    endcase
  end

  // ---- stage p0: held beat and left-neighbour history ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q       <= '0;
      cur_data_p0  <= '0;
      cur_user_p0  <= 1'b0;
      cur_mode_p0  <= '0;
      cur_first_p0 <= 1'b0;
      prev_tail_p0 <= '0;
    end else begin
      if (load_cur) begin
        cur_data_p0  <= in_data;
        cur_user_p0  <= in_user;
        cur_mode_p0  <= beat_mode;
        cur_first_p0 <= (state_q == EMPTY);
        if (in_user) mode_q <= mode;
      end
      if (emit && !emit_last) prev_tail_p0 <= cur_data_p0[BW-1 -: 2*PW];
    end
  end

  // ---- stage p1: output register ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_user  <= 1'b0;
      out_last  <= 1'b0;
    end else if (emit) begin
      out_data  <= emit_data;
      out_valid <= 1'b1;
      out_user  <= cur_user_p0;
      out_last  <= emit_last;
    end else if (slot_free) begin
      out_valid <= 1'b0;
      out_user  <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nr_hfilter_stream.sv
// Randomised bench for nr_hfilter_stream against a line-level reference model.
module tb_nr_hfilter_stream;

  localparam int PW  = 10;
  localparam int PPC = 4;
  localparam int BW  = PW * PPC;
  localparam logic [BW-1:0] TP = 40'h4018060300;

  typedef struct {
    logic [BW-1:0] d;
    logic          u;
    logic          l;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic [1:0]    mode;
  logic [BW-1:0] in_data;
  logic          in_valid;
  logic          in_user;
  logic          in_last;
  logic          in_ready;
  logic [BW-1:0] out_data;
  logic          out_valid;
  logic          out_user;
  logic          out_last;
  logic          out_ready;

  int            n_cmp = 0;
  int            n_err = 0;
  int            n_in  = 0;
  int            n_out = 0;
  bit            mon_en = 1'b1;
  bit            bp_en = 1'b0;
  bit            ready_hold = 1'b1;
  int            gap_max = 0;
  logic [1:0]    mode_m = 2'd0;
  int            line_px[$];
  exp_t          exp_q[$];
  logic [BW-1:0] got_q[$];

  logic          prev_stall = 1'b0;
  logic [BW-1:0] ps_d = '0;
  logic          ps_u = 1'b0;
  logic          ps_l = 1'b0;

  nr_hfilter_stream #(.PW(PW), .PPC(PPC), .TP_PATTERN(TP)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .mode      (mode),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_user   (in_user),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_user  (out_user),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [BW-1:0] v;
    v = '0;
    v[0*PW +: PW] = PW'(a);
    v[1*PW +: PW] = PW'(b);
    v[2*PW +: PW] = PW'(c);
    v[3*PW +: PW] = PW'(d);
    return v;
  endfunction

  function automatic logic [BW-1:0] beat_raw(input int b);
    logic [BW-1:0] v;
    v = '0;
    for (int k = 0; k < PPC; k++) v[k*PW +: PW] = PW'(line_px[b*PPC + k]);
    return v;
  endfunction

  // Whole-line view: neighbours are same-colour pixels two apart; off-line ones become C.
  function automatic logic [BW-1:0] model_beat(input int b, input logic [1:0] md);
    logic [BW-1:0] v;
    int n, j, cc, ll, rr;
    n = line_px.size();
    v = '0;
    if (md == 2'd1) return TP;
    if (md != 2'd2) return beat_raw(b);
    for (int k = 0; k < PPC; k++) begin
      j  = b*PPC + k;
      cc = line_px[j];
      ll = (j >= 2) ? line_px[j-2] : cc;
      rr = (j + 2 < n) ? line_px[j+2] : cc;
      v[k*PW +: PW] = PW'((ll + 2*cc + rr + 2) / 4);
    end
    return v;
  endfunction

  task automatic drive_raw(input logic [BW-1:0] d, input logic u, input logic l, input logic [1:0] m);
    int n;
    n = 0;
    in_data  = d;
    in_user  = u;
    in_last  = l;
    mode     = m;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        check("accept_timeout", 1, 0);
        break;
      end
    end
    if (mon_en) n_in++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_user  = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_line(input logic sof, input logic [1:0] md0, input logic [1:0] md1);
    int nb;
    logic bs;
    logic [1:0] mb;
    nb = line_px.size() / PPC;
    for (int b = 0; b < nb; b++) begin
      bs = sof && (b == 0);
      mb = (b == 0) ? md0 : md1;
      if (bs) mode_m = mb;
      exp_q.push_back('{model_beat(b, mode_m), bs, (b == nb - 1)});
    end
    for (int b = 0; b < nb; b++) begin
      repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      drive_raw(beat_raw(b), sof && (b == 0), (b == nb - 1), (b == 0) ? md0 : md1);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", 64'(n >= 500), 0);
  endtask

  task automatic fill_line(input int nb, input bit ramp);
    line_px.delete();
    for (int j = 0; j < nb*PPC; j++) line_px.push_back(ramp ? 16*j + 3 : int'($urandom_range(0, 1023)));
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = bp_en ? 1'($urandom_range(0, 1)) : ready_hold;
    end
  end

  // Output monitor: scoreboard on every transfer, stability while stalled.
  always @(negedge clk) begin
    if (rstn && mon_en) begin
      if (prev_stall)
        check("stall_hold", {out_valid, out_user, out_last, out_data}, {1'b1, ps_u, ps_l, ps_d});
      if (out_valid && out_ready) begin
        n_out <= n_out + 1;
        got_q.push_back(out_data);
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          check("out_data", out_data, exp_q[0].d);
          check("out_user_last", {out_user, out_last}, {exp_q[0].u, exp_q[0].l});
          exp_q.pop_front();
        end
      end
    end
    prev_stall <= rstn && mon_en && out_valid && !out_ready;
    ps_d <= out_data;
    ps_u <= out_user;
    ps_l <= out_last;
  end

  initial begin
    int bub;
    logic [BW-1:0] raw0;
    rstn = 1'b1; mode = 2'd0; in_data = '0; in_valid = 1'b0; in_user = 1'b0; in_last = 1'b0;
    #1 rstn = 1'b0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_user_last", {out_user, out_last}, 0);
    check("rst_in_ready", in_ready, 1);
    #19 rstn = 1'b1;
    @(posedge clk); #1;

    // Filter, two-beat line, and the single input bubble at end of line.
    got_q.delete();
    line_px = '{0, 0, 0, 0, 40, 40, 40, 40};
    send_line(1'b1, 2'd2, 2'd2);
    bub = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (in_ready) break;
      bub++;
    end
    check("eol_bubble", bub, 1);
    @(posedge clk); #1;
    wait_drain();
    check("filt_count", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      check("filt_beat0", got_q[0], pack4(0, 0, 10, 10));
      check("filt_beat1", got_q[1], pack4(30, 30, 40, 40));
    end

    // Bypass ramp, three beats.
    fill_line(3, 1'b1);
    send_line(1'b1, 2'd0, 2'd0);
    wait_drain();

    // Test pattern, two beats of random data.
    fill_line(2, 1'b0);
    send_line(1'b1, 2'd1, 2'd1);
    wait_drain();

    // Filter under random backpressure, four beats.
    bp_en = 1'b1;
    fill_line(4, 1'b0);
    send_line(1'b1, 2'd2, 2'd2);
    wait_drain();

    // Mid-line mode change is ignored until the next SOF.
    got_q.delete();
    fill_line(3, 1'b0);
    send_line(1'b1, 2'd2, 2'd0);
    fill_line(2, 1'b0);
    raw0 = beat_raw(0);
    send_line(1'b1, 2'd0, 2'd2);
    wait_drain();
    if (got_q.size() >= 4) check("switch_new_mode", got_q[3], raw0);
    else check("switch_count", got_q.size(), 5);

    // Single-beat line in filter mode.
    bp_en = 1'b0;
    got_q.delete();
    line_px = '{8, 4, 8, 4};
    send_line(1'b1, 2'd2, 2'd2);
    wait_drain();
    if (got_q.size() >= 1) check("single_beat", got_q[0], pack4(8, 4, 8, 4));
    else check("single_count", got_q.size(), 1);

    // Reset mid-line with a stalled output beat.
    mon_en = 1'b0;
    ready_hold = 1'b0;
    @(posedge clk); #1;
    fill_line(3, 1'b1);
    drive_raw(beat_raw(0), 1'b1, 1'b0, 2'd2);
    drive_raw(beat_raw(1), 1'b0, 1'b0, 2'd2);
    #2;
    check("pre_rst_valid", out_valid, 1);
    rstn = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_data", out_data, 0);
    check("async_rst_user_last", {out_user, out_last}, 0);
    exp_q.delete();
    mode_m = 2'd0;
    ready_hold = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    // mode_q was cleared, so a non-SOF line runs as bypass.
    fill_line(2, 1'b0);
    send_line(1'b0, 2'd2, 2'd2);
    wait_drain();

    // Random lines: lengths, modes, SOF placement, gaps and backpressure.
    bp_en = 1'b1;
    for (int t = 0; t < 30; t++) begin
      gap_max = $urandom_range(0, 2);
      fill_line($urandom_range(1, 5), 1'b0);
      send_line(1'($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end
    wait_drain();
    @(negedge clk);
    check("beat_conservation", n_out, n_in);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
